rx_top_control_module: RTL and testbench

Receive-side counterpart of the UART transmit path: samples the serial line, deserialises 8N1 frames, and pushes each good byte into the RX FIFO with a one-cycle write request. It sits between the external RX pin and the RX FIFO write port. It flags framing errors and counts bytes dropped because the FIFO was full.

---
 rtl/rx_top_control_module.sv | 160 ++++++++++++++++
 tb/tb_rx_top_control_module.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rx_top_control_module.sv
// UART 8N1 receiver front end: line synchroniser, frame deserialiser and RX FIFO write control
// with framing-error flagging and a saturating count of bytes dropped on a full FIFO.
module rx_top_control_module #(
    parameter int BAUD_DIV = 434
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_Pin_In,
    input  logic       RX_En_Sig,
    input  logic       Full_Sig,
    output logic       Write_Req_Sig,
    output logic [7:0] FIFO_Write_Data,
    output logic       Frame_Err_Sig,
    output logic       Overrun_Sig,
    output logic [7:0] Drop_Count
);

    localparam logic [15:0] HALF_CNT = 16'(BAUD_DIV / 2);
    localparam logic [15:0] BIT_LAST = 16'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WRITE,
        WAIT_HIGH
    } state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

    state_t      state;
    state_t      state_next;
    logic        rx_sync_p0;
    logic        rx_sync_p1;
    logic        rx_prev_p2;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_reg;
    logic        bit_tick;
    logic        stop_tick;
    logic        fall_edge;
    logic        stop_good;

    // Pin synchroniser plus one history stage; all reset high so reset never fakes a start edge
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_sync_p0 <= 1'b1;
            rx_sync_p1 <= 1'b1;
            rx_prev_p2 <= 1'b1;
        end else begin
            rx_sync_p0 <= RX_Pin_In;
            rx_sync_p1 <= rx_sync_p0;
            rx_prev_p2 <= rx_sync_p1;
        end
    end

    assign fall_edge = rx_prev_p2 & ~rx_sync_p1;
    assign stop_good = stop_tick & rx_sync_p1;

    always_comb begin
        state_next = state;
        bit_tick   = 1'b0;
        stop_tick  = 1'b0;
        unique case (state)
            IDLE: begin
                if (fall_edge && RX_En_Sig) begin
                    state_next = START;
                end
            end
            START: begin
                if (baud_cnt == HALF_CNT) begin
                    state_next = rx_sync_p1 ? IDLE : DATA;
                end
            end
            DATA: begin
                if (baud_cnt == BIT_LAST) begin
                    bit_tick = 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (baud_cnt == BIT_LAST) begin
                    stop_tick  = 1'b1;
                    state_next = rx_sync_p1 ? WRITE : WAIT_HIGH;
                end
            end
            WRITE: begin
                state_next = IDLE;
            end
            WAIT_HIGH: begin
                if (rx_sync_p1) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Counter restarts on every state change and after each data sample, so each bit is timed
    // from the previous sample point rather than from frame start.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            baud_cnt  <= 16'd0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'h00;
        end else begin
            if ((state_next != state) || bit_tick) begin
                baud_cnt <= 16'd0;
            end else if ((state == START) || (state == DATA) || (state == STOP)) begin
                baud_cnt <= baud_cnt + 16'd1;
            end
            if ((state == START) && (state_next == DATA)) begin
                bit_idx <= 3'd0;
            end else if (bit_tick) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (bit_tick) begin
                shift_reg[bit_idx] <= rx_sync_p1;
            end
        end
    end

    // Result pulses are registered at the stop-sample edge, so they are high exactly for the
    // single WRITE (or first WAIT_HIGH) cycle that follows the stop-bit sample.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Write_Req_Sig   <= 1'b0;
            Overrun_Sig     <= 1'b0;
            Frame_Err_Sig   <= 1'b0;
            FIFO_Write_Data <= 8'h00;
            Drop_Count      <= 8'h00;
        end else begin
            Write_Req_Sig <= stop_good & ~Full_Sig;
            Overrun_Sig   <= stop_good & Full_Sig;
            Frame_Err_Sig <= stop_tick & ~rx_sync_p1;
            if (stop_good && !Full_Sig) begin
                FIFO_Write_Data <= shift_reg;
            end
            if (stop_good && Full_Sig) begin
                Drop_Count <= sat_inc(Drop_Count);
            end
        end
    end

endmodule

// File: tb/tb_rx_top_control_module.sv
// Randomised self-checking bench for rx_top_control_module: a queue of expected frame outcomes
// is built from the frames the bench transmits and checked against DUT pulses every cycle.
module tb_rx_top_control_module;

    localparam int DIV = 8;
    localparam int WR = 1;
    localparam int OVR = 2;
    localparam int FERR = 3;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RX_Pin_In = 1'b1;
    logic       RX_En_Sig = 1'b1;
    logic       Full_Sig = 1'b0;
    logic       Write_Req_Sig;
    logic [7:0] FIFO_Write_Data;
    logic       Frame_Err_Sig;
    logic       Overrun_Sig;
    logic [7:0] Drop_Count;

    rx_top_control_module #(.BAUD_DIV(DIV)) dut (
        .CLK(CLK),
        .RST(RST),
        .RX_Pin_In(RX_Pin_In),
        .RX_En_Sig(RX_En_Sig),
        .Full_Sig(Full_Sig),
        .Write_Req_Sig(Write_Req_Sig),
        .FIFO_Write_Data(FIFO_Write_Data),
        .Frame_Err_Sig(Frame_Err_Sig),
        .Overrun_Sig(Overrun_Sig),
        .Drop_Count(Drop_Count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        ev;
    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         fall_cyc = 0;
    int         wr_cyc = 0;
    int         ovr_seen = 0;
    int         pulse_cnt = 0;
    int         mdl_drop = 0;
    logic [7:0] mdl_data = 8'h00;
    int         kind;
    int         hot;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Outcome of a frame follows only from how it was sent and the FIFO state during it
    task automatic send_frame(input logic [7:0] b, input bit full_v, input int stop_low_bits);
        ev_t e;
        Full_Sig = full_v;
        if (RX_En_Sig) begin
            e.data = b;
            if (stop_low_bits > 0) e.kind = FERR;
            else if (full_v) e.kind = OVR;
            else e.kind = WR;
            exp_q.push_back(e);
        end
        fall_cyc = cyc;
        RX_Pin_In = 1'b0;
        repeat (DIV) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            RX_Pin_In = b[i];
            repeat (DIV) @(negedge CLK);
        end
        if (stop_low_bits > 0) begin
            RX_Pin_In = 1'b0;
            repeat (DIV * stop_low_bits) @(negedge CLK);
        end
        RX_Pin_In = 1'b1;
        repeat (DIV) @(negedge CLK);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge CLK);
        check({"drain_", name}, exp_q.size(), 0);
    endtask

    always @(negedge CLK) begin
        if (RST) begin
            mdl_data = 8'h00;
            mdl_drop = 0;
        end else begin
            hot  = int'(Write_Req_Sig) + int'(Overrun_Sig) + int'(Frame_Err_Sig);
            kind = Write_Req_Sig ? WR : (Overrun_Sig ? OVR : (Frame_Err_Sig ? FERR : 0));
            check("one_hot", (hot > 1) ? 1 : 0, 0);
            if (kind != 0) begin
                pulse_cnt++;
                if (kind == WR) wr_cyc = cyc;
                if (kind == OVR) ovr_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", kind, 0);
                end else begin
                    ev = exp_q.pop_front();
                    check("event_kind", kind, ev.kind);
                    if (ev.kind == WR) mdl_data = ev.data;
                    if (ev.kind == OVR) mdl_drop = (mdl_drop >= 255) ? 255 : mdl_drop + 1;
                end
            end
            check("write_data", int'(FIFO_Write_Data), int'(mdl_data));
            check("drop_count", int'(Drop_Count), mdl_drop);
        end
    end

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int o0;
        logic [7:0] b;
        repeat (3) @(negedge CLK);
        check("rst_write_req", int'(Write_Req_Sig), 0);
        check("rst_frame_err", int'(Frame_Err_Sig), 0);
        check("rst_overrun", int'(Overrun_Sig), 0);
        check("rst_data", int'(FIFO_Write_Data), 0);
        check("rst_drop", int'(Drop_Count), 0);
        RST = 1'b0;
        repeat (5) @(negedge CLK);

        send_frame(8'hA5, 1'b0, 0);
        drain("a5");
        check("a5_latency_window", ((wr_cyc - fall_cyc >= 78) && (wr_cyc - fall_cyc <= 80)) ? 1 : 0, 1);
        check("a5_data", int'(FIFO_Write_Data), 8'hA5);

        p0 = pulse_cnt;
        RX_Pin_In = 1'b0;
        repeat (2) @(negedge CLK);
        RX_Pin_In = 1'b1;
        repeat (40) @(negedge CLK);
        check("glitch_no_pulse", pulse_cnt - p0, 0);
        send_frame(8'h55, 1'b0, 0);
        drain("55");
        check("55_data", int'(FIFO_Write_Data), 8'h55);

        p0 = pulse_cnt;
        send_frame(8'hFF, 1'b0, 3);
        drain("ferr");
        check("ferr_one_pulse", pulse_cnt - p0, 1);
        check("ferr_data_held", int'(FIFO_Write_Data), 8'h55);
        send_frame(8'h01, 1'b0, 0);
        drain("01");
        check("01_data", int'(FIFO_Write_Data), 8'h01);

        for (int i = 0; i < 40; i++) begin
            b = 8'($urandom);
            send_frame(b, ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0) ? 1 : 0);
            repeat ($urandom_range(0, 12)) @(negedge CLK);
        end
        drain("random");

        Full_Sig = 1'b0;
        fork
            begin
                send_frame(8'h00, 1'b0, 0);
                send_frame(8'hFF, 1'b0, 0);
                send_frame(8'h81, 1'b0, 0);
            end
            begin
                repeat (DIV * 10 + 20) @(negedge CLK);
                RX_En_Sig = 1'b0;
                repeat (30) @(negedge CLK);
                RX_En_Sig = 1'b1;
            end
        join
        drain("b2b");
        check("b2b_last_data", int'(FIFO_Write_Data), 8'h81);

        RX_En_Sig = 1'b0;
        p0 = pulse_cnt;
        send_frame(8'h5A, 1'b0, 0);
        repeat (20) @(negedge CLK);
        check("disabled_ignored", pulse_cnt - p0, 0);
        RX_En_Sig = 1'b1;
        repeat (5) @(negedge CLK);
        send_frame(8'h3C, 1'b0, 0);
        drain("en_3c");

        o0 = ovr_seen;
        p0 = pulse_cnt;
        for (int i = 0; i < 300; i++) begin
            send_frame(8'($urandom), 1'b1, 0);
            repeat ($urandom_range(0, 3)) @(negedge CLK);
        end
        drain("overrun");
        check("ovr_pulses", ovr_seen - o0, 300);
        check("ovr_no_writes", pulse_cnt - p0, 300);
        check("drop_saturated", int'(Drop_Count), 255);
        send_frame(8'h7E, 1'b0, 0);
        drain("7e");
        check("7e_data", int'(FIFO_Write_Data), 8'h7E);

        RX_Pin_In = 1'b0;
        repeat (DIV * 3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check("midrst_write_req", int'(Write_Req_Sig), 0);
        check("midrst_overrun", int'(Overrun_Sig), 0);
        check("midrst_frame_err", int'(Frame_Err_Sig), 0);
        check("midrst_data", int'(FIFO_Write_Data), 0);
        check("midrst_drop", int'(Drop_Count), 0);
        RX_Pin_In = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (20) @(negedge CLK);
        send_frame(8'h3C, 1'b0, 0);
        drain("post_rst_3c");
        check("post_rst_data", int'(FIFO_Write_Data), 8'h3C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
